smc_sort_stage: RTL and testbench

- Sequential front-end of the Supper MOSFET Calculator datapath.
- Receives opt and five unsigned 4-bit operands serially, one per cycle.
- Sorts the operands with an iterative odd-even transposition network, one phase per cycle, then applies the optional mid-range offset.
- Presents the five conditioned signed operands plus opt[2] to the downstream combinational equation stage.

---
 rtl/smc_pkg.sv | 28 ++
 rtl/smc_cmp_swap.sv | 22 ++
 rtl/smc_sort_stage.sv | 182 ++++++++++++++++++
 tb/tb_smc_sort_stage.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/smc_pkg.sv
// Shared constants, state encoding and operand type for the SMC sort stage.
package smc_pkg;

  localparam int IN_W  = 4;
  localparam int OUT_W = IN_W + 1;
  localparam int N_OPS = 5;
  localparam int CNT_W = 3;

  // Index of the last operand slot, also the last sort phase.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_OPS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SORT   = 3'd2,
    OFFSET = 3'd3,
    OUT    = 3'd4
  } state_t;

  // Conditioned operand: signed two's complement, one bit wider than the input.
  typedef logic signed [OUT_W-1:0] op_t;

  // Zero-extend a raw unsigned operand into the signed slot format.
  function automatic op_t zext(input logic [IN_W-1:0] v);
    return op_t'({{(OUT_W - IN_W){1'b0}}, v});
  endfunction

endpackage

// File: rtl/smc_cmp_swap.sv
// Compare-swap cell: orders one pair of operands for the transposition network.
// lo_first is the value for the lower slot index, hi_first for the higher one.
module smc_cmp_swap
  import smc_pkg::*;
(
  input  op_t  a,
  input  op_t  b,
  input  logic desc,
  output op_t  lo_first,
  output op_t  hi_first
);

  logic swap;

  // Swap only on strict inequality so equal values keep their order.
  always_comb begin
    swap     = desc ? (a < b) : (a > b);
    lo_first = swap ? b : a;
    hi_first = swap ? a : b;
  end

endmodule

// File: rtl/smc_sort_stage.sv
// Sequential front-end of the SMC datapath: collects five operands serially,
// sorts them with an odd-even transposition network (one phase per cycle),
// applies the optional mid-range offset and presents a one-cycle result.
//
// Handshake: in_valid qualifies in_data on each rising edge; a packet is
// exactly N_OPS consecutive valid cycles. There is no ready signal: the stage
// accepts input only while busy=0 and silently ignores in_valid while busy=1.
// out_valid is a single-cycle strobe with no back-pressure; eq_sel and out_n*
// are zero whenever out_valid is low.
module smc_sort_stage
  import smc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [2:0]      opt,
  input  logic [IN_W-1:0] in_data,
  output logic            busy,
  output logic            out_valid,
  output logic            eq_sel,
  output op_t             out_n0,
  output op_t             out_n1,
  output op_t             out_n2,
  output op_t             out_n3,
  output op_t             out_n4,
  output state_t          dbg_state
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  phase_q;
  logic [2:0]        opt_q;
  op_t               slot_q [N_OPS];
  op_t               out_q  [N_OPS];
  logic              out_valid_q;
  logic              eq_sel_q;

  // Compare-swap cell ports, muxed by phase parity.
  op_t ca_a, ca_b, ca_lo, ca_hi;
  op_t cb_a, cb_b, cb_lo, cb_hi;
  op_t sort_d [N_OPS];

  // Offset datapath.
  logic [OUT_W:0]    sum;
  op_t               mid;
  op_t               cond_d [N_OPS];

  smc_cmp_swap u_cell_a (
    .a        (ca_a),
    .b        (ca_b),
    .desc     (opt_q[1]),
    .lo_first (ca_lo),
    .hi_first (ca_hi)
  );

  smc_cmp_swap u_cell_b (
    .a        (cb_a),
    .b        (cb_b),
    .desc     (opt_q[1]),
    .lo_first (cb_lo),
    .hi_first (cb_hi)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a short packet in LOAD falls back to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (in_valid) state_d = LOAD;
      LOAD: begin
        if (!in_valid)                 state_d = IDLE;
        else if (count_q == LAST_IDX)  state_d = SORT;
      end
      SORT:   if (phase_q == LAST_IDX) state_d = OFFSET;
      OFFSET: state_d = OUT;
      OUT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Route slot pairs to the two cells: even phases (0,1),(2,3); odd (1,2),(3,4).
  always_comb begin
    if (!phase_q[0]) begin
      ca_a = slot_q[0]; ca_b = slot_q[1];
      cb_a = slot_q[2]; cb_b = slot_q[3];
    end else begin
      ca_a = slot_q[1]; ca_b = slot_q[2];
      cb_a = slot_q[3]; cb_b = slot_q[4];
    end
  end

  // Reassemble the slot vector after one transposition phase.
  always_comb begin
    sort_d = slot_q;
    if (!phase_q[0]) begin
      sort_d[0] = ca_lo; sort_d[1] = ca_hi;
      sort_d[2] = cb_lo; sort_d[3] = cb_hi;
    end else begin
      sort_d[1] = ca_lo; sort_d[2] = ca_hi;
      sort_d[3] = cb_lo; sort_d[4] = cb_hi;
    end
  end

  // Mid-range offset: slots 0 and 4 hold the extremes after sorting, both
  // nonnegative, so the shift is an exact truncating halve (max 15).
  always_comb begin
    sum = {1'b0, slot_q[0]} + {1'b0, slot_q[N_OPS-1]};
    mid = op_t'(sum >> 1);
    for (int i = 0; i < N_OPS; i++) begin
      cond_d[i] = opt_q[0] ? (slot_q[i] - mid) : slot_q[i];
    end
  end

  // Operand capture, sort phases, offset and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      phase_q     <= '0;
      opt_q       <= '0;
      out_valid_q <= 1'b0;
      eq_sel_q    <= 1'b0;
      for (int i = 0; i < N_OPS; i++) begin
        slot_q[i] <= '0;
        out_q[i]  <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            opt_q     <= opt;
            slot_q[0] <= zext(in_data);
            count_q   <= CNT_W'(1);
          end
        end
        LOAD: begin
          if (in_valid) begin
            slot_q[count_q] <= zext(in_data);
            count_q         <= count_q + CNT_W'(1);
            phase_q         <= '0;
          end else begin
            count_q <= '0;
          end
        end
        SORT: begin
          slot_q  <= sort_d;
          phase_q <= phase_q + CNT_W'(1);
        end
        OFFSET: begin
          slot_q      <= cond_d;
          out_q       <= cond_d;
          out_valid_q <= 1'b1;
          eq_sel_q    <= opt_q[2];
        end
        OUT: begin
          count_q     <= '0;
          out_valid_q <= 1'b0;
          eq_sel_q    <= 1'b0;
          for (int i = 0; i < N_OPS; i++) out_q[i] <= '0;
        end
        default: begin
          count_q <= '0;
        end
      endcase
    end
  end

  assign busy      = (state_q == SORT) || (state_q == OFFSET) || (state_q == OUT);
  assign out_valid = out_valid_q;
  assign eq_sel    = eq_sel_q;
  assign out_n0    = out_q[0];
  assign out_n1    = out_q[1];
  assign out_n2    = out_q[2];
  assign out_n3    = out_q[3];
  assign out_n4    = out_q[4];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_smc_sort_stage.sv
// Directed bench for smc_sort_stage: stimulus pushes expected results and
// strobe cycles into queues; a negedge monitor pops and compares.
module tb_smc_sort_stage;
  import smc_pkg::*;

  localparam int W = 1 + 5 * OUT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic            in_valid = 1'b0;
  logic [2:0]      opt      = 3'b000;
  logic [IN_W-1:0] in_data  = '0;
  logic            busy, out_valid, eq_sel;
  op_t             out_n0, out_n1, out_n2, out_n3, out_n4;
  state_t          dbg_state;

  smc_sort_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .opt       (opt),
    .in_data   (in_data),
    .busy      (busy),
    .out_valid (out_valid),
    .eq_sel    (eq_sel),
    .out_n0    (out_n0),
    .out_n1    (out_n1),
    .out_n2    (out_n2),
    .out_n3    (out_n3),
    .out_n4    (out_n4),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  int           n_cmp = 0;
  int           n_err = 0;

  function automatic logic [W-1:0] pack(input logic e, input int a, input int b,
                                        input int c, input int d, input int f);
    return {e, 5'(a), 5'(b), 5'(c), 5'(d), 5'(f)};
  endfunction

  logic [W-1:0] act;
  assign act = {eq_sel, out_n0, out_n1, out_n2, out_n3, out_n4};

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Monitor: pops one expectation per strobe, checks latency, and checks
  // that outputs sit at zero whenever no strobe is present.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_out_valid: got strobe at cycle %0d want none", cyc);
      end else begin
        check("result", act, exp_q.pop_front());
        check("latency", W'(cyc), W'(exp_cyc_q.pop_front()));
      end
    end else begin
      check("idle_zero", {out_valid, act[W-2:0]} | W'(eq_sel), '0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL wait_idle: busy=%b after %0d cycles want 0", busy, n);
    end
  endtask

  // Drives n_send operands; a full packet queues its expectation.
  task automatic send_pkt(input logic [2:0] o, input int d0, input int d1, input int d2,
                          input int d3, input int d4, input int n_send,
                          input logic [W-1:0] exp);
    logic [IN_W-1:0] d[5];
    d[0] = IN_W'(d0); d[1] = IN_W'(d1); d[2] = IN_W'(d2); d[3] = IN_W'(d3); d[4] = IN_W'(d4);
    for (int i = 0; i < n_send; i++) begin
      in_valid = 1'b1;
      opt      = (i == 0) ? o : ~o;
      in_data  = d[i];
      @(posedge clk); #1;
      if (i == 1) check("busy_in_load", W'(busy), W'(0));
    end
    in_valid = 1'b0;
    in_data  = '0;
    if (n_send == N_OPS) begin
      exp_q.push_back(exp);
      exp_cyc_q.push_back(cyc + 6);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", W'(exp_q.size()), W'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1;
    check("reset_outputs", act, '0);
    check("reset_busy", W'({busy, out_valid}), W'(0));
    check("reset_state", W'(dbg_state), W'(IDLE));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Ascending, no offset.
    send_pkt(3'b000, 9, 3, 15, 0, 7, 5, pack(1'b0, 0, 3, 7, 9, 15));
    wait_idle();
    // Descending.
    send_pkt(3'b010, 9, 3, 15, 0, 7, 5, pack(1'b0, 15, 9, 7, 3, 0));
    wait_idle();
    // Ascending with offset and equation select: mid=(0+15)>>1=7.
    send_pkt(3'b101, 9, 3, 15, 0, 7, 5, pack(1'b1, -7, -4, 0, 2, 8));
    wait_idle();
    // Descending with duplicates, offset: 2,1,1,1,1 mid=1.
    send_pkt(3'b011, 1, 1, 1, 1, 2, 5, pack(1'b0, 1, 0, 0, 0, 0));
    wait_idle();
    // Descending with eq_sel only.
    send_pkt(3'b110, 9, 3, 15, 0, 7, 5, pack(1'b1, 15, 9, 7, 3, 0));
    wait_idle();
    drain();

    // Short packet is discarded, then a full packet.
    send_pkt(3'b111, 8, 8, 8, 0, 0, 3, '0);
    repeat (3) @(posedge clk);
    #1;
    check("short_pkt_idle", W'(dbg_state), W'(IDLE));
    send_pkt(3'b000, 5, 4, 3, 2, 1, 5, pack(1'b0, 1, 2, 3, 4, 5));
    // in_valid pulses while busy must be ignored.
    for (int i = 0; i < 3; i++) begin
      check("busy_in_sort", W'(busy), W'(1));
      in_valid = 1'b1;
      opt      = 3'($urandom_range(0, 7));
      in_data  = IN_W'($urandom_range(0, 15));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_idle();
    drain();

    // Reset during sort phase 2 loses the packet.
    send_pkt(3'b000, 9, 3, 15, 0, 7, 5, pack(1'b0, 0, 3, 7, 9, 15));
    @(posedge clk); @(posedge clk);
    #2;
    check("pre_reset_busy", W'(busy), W'(1));
    rst = 1'b1;
    void'(exp_q.pop_back());
    void'(exp_cyc_q.pop_back());
    #1;
    check("async_reset_out", {out_valid, act[W-2:0]} | W'(eq_sel), '0);
    check("async_reset_busy", W'(busy), W'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    // Next packet: ascending 0,0,8,15,15 mid=7.
    send_pkt(3'b001, 15, 15, 0, 0, 8, 5, pack(1'b0, -7, -7, 1, 8, 8));
    wait_idle();
    drain();
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
